// File: rtl/cmp_arb_pkg.sv
// ============================================================================
// Module      : cmp_arb_pkg
// Description : Shared widths, FSM state encoding and compare helper for
//               the two-requester compare arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_arb_pkg;

    localparam int OP_W  = 3;
    localparam int RES_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCH   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Bit-equality vector in the low bits, all-equal flag on top.
    function automatic logic [RES_W-1:0] cmp_res(input logic [OP_W-1:0] a,
                                                 input logic [OP_W-1:0] b);
        logic [OP_W-1:0] eq;
        eq = ~(a ^ b);
        return {&eq, eq};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_arb_prio.sv
// ============================================================================
// Module      : cmp_arb_prio
// Description : Winner selection between two requesters (0 = requester 0).
//               CMP_ARB_FIXED_PRIO_EN: requester 0 always wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_arb_prio
    import cmp_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic winner
);

`ifdef CMP_ARB_FIXED_PRIO_EN
    logic unused_pointer;
    assign unused_pointer = pointer;
    assign winner         = req1 & ~req0;
`else
    // A lone request wins outright; on a tie the pointer decides.
    assign winner = req1 & (~req0 | pointer);
`endif

endmodule

`default_nettype wire

// File: rtl/cmp_arbiter.sv
// ============================================================================
// Module      : cmp_arbiter
// Description : Two-requester arbiter feeding a 3-bit equality comparator;
//               4-cycle IDLE/LATCH/COMPARE/DONE operation.
//               Option macro: CMP_ARB_FIXED_PRIO_EN (fixed priority, no pointer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_arbiter
    import cmp_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [OP_W-1:0]  a0,
    input  logic [OP_W-1:0]  b0,
    input  logic [OP_W-1:0]  a1,
    input  logic [OP_W-1:0]  b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [RES_W-1:0] res,
    output logic             busy
);

    state_e            state_q, state_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic [OP_W-1:0]   opa_q, opa_d;
    logic [OP_W-1:0]   opb_q, opb_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              ptr_q;
    logic              winner;

`ifdef CMP_ARB_FIXED_PRIO_EN
    assign ptr_q = 1'b0;
`else
    // Favour the loser of the operation that just completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (state_q == DONE) begin
            ptr_q <= gnt0_q;
        end
    end
`endif

    cmp_arb_prio u_prio (
        .req0    (req0),
        .req1    (req1),
        .pointer (ptr_q),
        .winner  (winner)
    );

    always_comb begin
        state_d = state_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = LATCH;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                end
            end
            LATCH: begin
                state_d = COMPARE;
                opa_d   = gnt1_q ? a1 : a0;
                opb_d   = gnt1_q ? b1 : b0;
            end
            COMPARE: begin
                state_d = DONE;
                res_d   = cmp_res(opa_q, opb_q);
            end
            DONE: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = (state_q == DONE) && gnt0_q;
    assign done1 = (state_q == DONE) && gnt1_q;
    assign res   = res_q;
    assign busy  = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
// ============================================================================
// Module      : tb_cmp_arbiter
// Description : Scoreboard bench for cmp_arbiter; honours CMP_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [2:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [3:0] res;

    typedef struct packed {
        logic       id;
        logic [3:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic m_ptr    = 1'b0;

    cmp_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .res   (res),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic predict(input logic r0, input logic r1);
`ifdef CMP_ARB_FIXED_PRIO_EN
        return !r0 && r1;
`else
        return (r0 && r1) ? m_ptr : (!r0 && r1);
`endif
    endfunction

    function automatic logic [3:0] exp_res(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] x;
        x = ~(a ^ b);
        return {x[0] & x[1] & x[2], x};
    endfunction

    // One full operation starting in IDLE; returns in the IDLE cycle after DONE.
    task automatic run_op(input logic r0, input logic r1,
                          input logic [2:0] va0, input logic [2:0] vb0,
                          input logic [2:0] va1, input logic [2:0] vb1,
                          input bit drop, input bit scramble);
        logic       w;
        logic [3:0] er;
        exp_t       e;
        int         lat;
        bit         seen;
        req0 = r0; req1 = r1;
        a0 = va0; b0 = vb0; a1 = va1; b1 = vb1;
        w  = predict(r0, r1);
        er = w ? exp_res(va1, vb1) : exp_res(va0, vb0);
        sb.push_back('{id: w, res: er});
        check("busy_idle", busy, 0);
        tick();
        check("gnt0_latch", gnt0, !w);
        check("gnt1_latch", gnt1, w);
        check("busy_latch", busy, 1);
        if (drop) begin
            req0 = 1'b0; req1 = 1'b0;
        end
        tick();
        if (scramble) begin
            a0 = ~va0; b0 = ~vb0 ^ 3'b010; a1 = ~va1; b1 = ~vb1;
        end
        check("nodone_cmp", done0 | done1, 0);
        seen = 1'b0;
        lat  = 2;
        while (!seen && lat < 8) begin
            tick();
            lat++;
            if (done0 | done1) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        if (seen) begin
            e = sb.pop_front();
            check("latency", lat, 3);
            check("done0", done0, !e.id);
            check("done1", done1, e.id);
            check("res", res, e.res);
            check("gnt_excl", gnt0 & gnt1, 0);
            check("gnt_done", {gnt1, gnt0}, {e.id, !e.id});
        end else begin
            sb.delete();
        end
        tick();
        check("done_clr", done0 | done1, 0);
        check("gnt_clr", gnt0 | gnt1, 0);
        check("res_hold", res, er);
        m_ptr = ~w;
    endtask

    task automatic release_reqs(input int n);
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("busy_norq", busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick(); tick();
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_done", {done1, done0}, 0);
        check("rst_res", res, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Single requester 0, equal operands
        run_op(1, 0, 3'b101, 3'b101, 3'b000, 3'b000, 0, 0);
        release_reqs(2);

        // Single requester 1 wins regardless of pointer
        run_op(0, 1, 3'b000, 3'b000, 3'b110, 3'b011, 0, 0);
        release_reqs(1);

        // Both requests held for four back-to-back operations
        for (int i = 0; i < 4; i++) begin
            run_op(1, 1, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 0, 0);
        end
        release_reqs(1);

        // Operand change after latching must be ignored
        run_op(1, 0, 3'b000, 3'b000, 3'b101, 3'b010, 0, 1);
        release_reqs(1);

        // Reset during COMPARE aborts the operation
        req0 = 1'b1; req1 = 1'b1;
        a0 = 3'b011; b0 = 3'b001; a1 = 3'b100; b1 = 3'b100;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        check("abort_done", done0 | done1, 0);
        check("abort_res", res, 0);
        check("abort_busy", busy, 0);
        check("abort_gnt", gnt0 | gnt1, 0);
        m_ptr = 1'b0;
        tick();
        check("abort_nodone", done0 | done1, 0);
        run_op(1, 1, 3'b111, 3'b011, 3'b000, 3'b001, 0, 0);
        release_reqs(1);

        // Requester 0 drops its request during LATCH
        run_op(0, 1, 3'b000, 3'b000, 3'b010, 3'b010, 0, 0);
        release_reqs(1);
        run_op(1, 0, 3'b110, 3'b100, 3'b000, 3'b000, 1, 0);
        run_op(1, 1, 3'b001, 3'b001, 3'b101, 3'b100, 0, 0);
        release_reqs(1);

        // Random request patterns
        for (int i = 0; i < 8; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            run_op(r[0], r[1], 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 0, 0);
            if ($urandom_range(0, 1) == 0) release_reqs(1);
        end
        release_reqs(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
